// File: rtl/load_store_unit_if.sv
// Request/response and word-memory bus shared by the load/store unit and its requester.
// The slave modport is the unit's view; the master modport is the execute stage / memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memoryWrite;
   logic        memoryRead;
   logic [31:0] readData;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
      output req_ready, resp_valid, resp_error, resp_rdata,
      output address, writeData, memoryWrite, memoryRead
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
      input  req_ready, resp_valid, resp_error, resp_rdata,
      input  address, writeData, memoryWrite, memoryRead
   );
endinterface

// File: rtl/load_store_unit.sv
// Serialised byte/half/word load-store unit in front of a big-endian word-only memory.
// Define LSU_PERF_CNT_EN to add saturating load_count/store_count outputs.
module load_store_unit #(
   parameter int MEM_BYTES = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   load_store_unit_if.slave     bus
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [15:0]          load_count,
   output logic [15:0]          store_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic        req_misaligned;
   logic        req_out_of_range;
   logic        req_bad;
   logic [4:0]  lane_base;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;
   logic [31:0] merged_word;

   // Request checks look only at the live request; they matter only on the accept edge.
   always_comb begin
      req_misaligned   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      req_out_of_range = ({1'b0, bus.req_addr[31:2], 2'b11} >= 33'(MEM_BYTES));
      req_bad          = req_misaligned || req_out_of_range || (bus.req_size == 2'b11);
   end

   // Big-endian: byte offset k lives at bit 8*(3-k), i.e. {~k, 3'b000}.
   always_comb begin
      lane_base   = {~addr_q[1:0], 3'b000};
      load_byte   = bus.readData[lane_base +: 8];
      load_half   = addr_q[1] ? bus.readData[15:0] : bus.readData[31:16];
      load_value  = bus.readData;
      merged_word = bus.readData;
      case (size_q)
         2'b00: begin
            load_value = signed_q ? {{24{load_byte[7]}}, load_byte} : {24'd0, load_byte};
            merged_word[lane_base +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_value = signed_q ? {{16{load_half[15]}}, load_half} : {16'd0, load_half};
            if (addr_q[1]) begin
               merged_word[15:0] = wdata_q[15:0];
            end else begin
               merged_word[31:16] = wdata_q[15:0];
            end
         end
         default: begin
            load_value  = bus.readData;
            merged_word = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d  = bus.req_write;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               rdata_d  = 32'd0;
               error_d  = req_bad;
               if (req_bad) begin
                  state_d = RESP;
               end else if (bus.req_write && (bus.req_size == 2'b10)) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            state_d = CAPTURE;
         end
         // wdata_q becomes the merged word so WRITE always drives a complete word.
         CAPTURE: begin
            if (write_q) begin
               wdata_d = merged_word;
               state_d = WRITE;
            end else begin
               rdata_d = load_value;
               state_d = RESP;
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Memory strobes come only from state, so reset drops them immediately.
   assign bus.req_ready   = (state_q == IDLE);
   assign bus.resp_valid  = (state_q == RESP);
   assign bus.resp_error  = (state_q == RESP) && error_q;
   assign bus.resp_rdata  = (state_q == RESP) ? rdata_q : 32'd0;
   assign bus.memoryRead  = (state_q == READ);
   assign bus.memoryWrite = (state_q == WRITE);
   assign bus.address     = {addr_q[31:2], 2'b00};
   assign bus.writeData   = wdata_q;

`ifdef LSU_PERF_CNT_EN
   logic [15:0] load_count_q, load_count_d;
   logic [15:0] store_count_q, store_count_d;

   always_comb begin
      load_count_d  = load_count_q;
      store_count_d = store_count_q;
      if ((state_q == RESP) && !error_q) begin
         if (write_q) begin
            if (store_count_q != 16'hFFFF) begin
               store_count_d = store_count_q + 16'd1;
            end
         end else begin
            if (load_count_q != 16'hFFFF) begin
               load_count_d = load_count_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_count_q  <= 16'd0;
         store_count_q <= 16'd0;
      end else begin
         load_count_q  <= load_count_d;
         store_count_q <= store_count_d;
      end
   end

   assign load_count  = load_count_q;
   assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized requests
// against a byte-array reference memory, mid-operation reset and optional perf counters.
module tb_load_store_unit;
   localparam int MEM_BYTES = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   load_store_unit_if bus();

`ifdef LSU_PERF_CNT_EN
   logic [15:0] load_count;
   logic [15:0] store_count;
`endif

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus)
`ifdef LSU_PERF_CNT_EN
      ,
      .load_count (load_count),
      .store_count(store_count)
`endif
   );

   always #5 clk = ~clk;

   // Big-endian word memory with a registered read port.
   logic [7:0] mem [MEM_BYTES];
   logic [5:0] mem_idx;
   assign mem_idx = bus.address[5:0];

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i * 7 + 3);
   end

   always @(posedge clk) begin
      if (bus.memoryRead) begin
         if (bus.address < 32'(MEM_BYTES))
            bus.readData <= {mem[mem_idx], mem[mem_idx + 6'd1], mem[mem_idx + 6'd2], mem[mem_idx + 6'd3]};
         else
            bus.readData <= 32'hDEADBEEF;
      end
      if (bus.memoryWrite && (bus.address < 32'(MEM_BYTES))) begin
         mem[mem_idx]        <= bus.writeData[31:24];
         mem[mem_idx + 6'd1] <= bus.writeData[23:16];
         mem[mem_idx + 6'd2] <= bus.writeData[15:8];
         mem[mem_idx + 6'd3] <= bus.writeData[7:0];
      end
   end

   logic [7:0] ref_mem [MEM_BYTES];

   int pass_count = 0;
   int check_count = 0;

   logic [31:0] obs_rdata;
   logic        obs_error;
   int          obs_latency;
   int          obs_reads;
   int          obs_writes;
   logic [31:0] obs_waddr;
   logic [31:0] obs_wdata;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] ad;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          reads;
      int          writes;
      logic [31:0] wword;
   } vec_t;

   vec_t vecs [18];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Reference: memory as a flat byte array, lowest address most significant.
   task automatic refModel(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic err, output logic [31:0] rd, output int lat,
                           output int reads, output int writes, output logic [31:0] wword);
      longint base;
      int n;
      logic [31:0] val;
      logic mis;
      n = 1 << sz;
      base = longint'(ad) - (longint'(ad) % 4);
      mis = ((sz == 2'd1) && (ad % 2 != 0)) || ((sz == 2'd2) && (ad % 4 != 0));
      err = (sz == 2'd3) || mis || (base + 3 >= MEM_BYTES);
      rd = 32'd0;
      wword = 32'd0;
      reads = 0;
      writes = 0;
      if (err) begin
         lat = 1;
      end else if (wr) begin
         for (int i = 0; i < n; i++) ref_mem[int'(ad) + i] = 8'(wd >> (8 * (n - 1 - i)));
         writes = 1;
         reads = (n == 4) ? 0 : 1;
         lat = (n == 4) ? 2 : 4;
         wword = {ref_mem[int'(base)], ref_mem[int'(base) + 1], ref_mem[int'(base) + 2], ref_mem[int'(base) + 3]};
      end else begin
         val = 32'd0;
         for (int i = 0; i < n; i++) val = (val << 8) | 32'(ref_mem[int'(ad) + i]);
         if (sg && (n < 4) && val[8 * n - 1]) val = val | (32'hFFFFFFFF << (8 * n));
         rd = val;
         reads = 1;
         lat = 3;
      end
   endtask

   // Issues one request and records the response and the memory strobes it caused.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] ad, input logic [31:0] wd);
      int waited;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = ad;
      bus.req_wdata  = wd;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      obs_rdata = 32'd0;
      obs_error = 1'b0;
      obs_latency = 0;
      obs_reads = 0;
      obs_writes = 0;
      obs_waddr = 32'd0;
      obs_wdata = 32'd0;
      for (int c = 1; c <= 16 && obs_latency == 0; c++) begin
         @(negedge clk);
         if (c == 1) bus.req_valid = 1'b0;
         if (bus.memoryRead) obs_reads++;
         if (bus.memoryWrite) begin
            obs_writes++;
            obs_waddr = bus.address;
            obs_wdata = bus.writeData;
         end
         if (bus.resp_valid) begin
            obs_latency = c;
            obs_rdata = bus.resp_rdata;
            obs_error = bus.resp_error;
         end
      end
   endtask

   initial begin
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat;
      int          e_reads;
      int          e_writes;
      logic [31:0] e_wword;
      logic        r_wr;
      logic [1:0]  r_sz;
      logic        r_sg;
      logic [31:0] r_ad;
      logic [31:0] r_wd;

      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 3);

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'd8,     32'hA1B2C3D4, 1'b0, 32'h00000000, 2, 0, 1, 32'hA1B2C3D4};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'd9,     32'h0,        1'b0, 32'hFFFFFFB2, 3, 1, 0, 32'h0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'd9,     32'h0,        1'b0, 32'h000000B2, 3, 1, 0, 32'h0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'd10,    32'h0,        1'b0, 32'hFFFFC3D4, 3, 1, 0, 32'h0};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'd10,    32'hFFFFFF55, 1'b0, 32'h00000000, 4, 1, 1, 32'hA1B255D4};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'd8,     32'h0,        1'b0, 32'hA1B255D4, 3, 1, 0, 32'h0};
      vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'd6,     32'h0,        1'b1, 32'h00000000, 1, 0, 0, 32'h0};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'd3,     32'h00001234, 1'b1, 32'h00000000, 1, 0, 0, 32'h0};
      vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'd0,     32'h0,        1'b1, 32'h00000000, 1, 0, 0, 32'h0};
      vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'd64,    32'h0,        1'b1, 32'h00000000, 1, 0, 0, 32'h0};
      vecs[10] = '{1'b0, 2'd2, 1'b1, 32'd60,    32'h0,        1'b0, 32'hA7AEB5BC, 3, 1, 0, 32'h0};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 32'd62,    32'hABCD1234, 1'b0, 32'h00000000, 4, 1, 1, 32'hA7AE1234};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 32'd62,    32'h0,        1'b0, 32'h00001234, 3, 1, 0, 32'h0};
      vecs[13] = '{1'b0, 2'd0, 1'b1, 32'd60,    32'h0,        1'b0, 32'hFFFFFFA7, 3, 1, 0, 32'h0};
      vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h100,   32'h000000EE, 1'b1, 32'h00000000, 1, 0, 0, 32'h0};
      vecs[15] = '{1'b0, 2'd0, 1'b0, 32'd11,    32'h0,        1'b0, 32'h000000D4, 3, 1, 0, 32'h0};
      vecs[16] = '{1'b1, 2'd1, 1'b0, 32'd8,     32'h00007777, 1'b0, 32'h00000000, 4, 1, 1, 32'h777755D4};
      vecs[17] = '{1'b0, 2'd2, 1'b0, 32'd8,     32'h0,        1'b0, 32'h777755D4, 3, 1, 0, 32'h0};

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;

      repeat (3) @(negedge clk);
      checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("reset memoryRead", 32'(bus.memoryRead), 32'd0);
      checkOutput("reset memoryWrite", 32'(bus.memoryWrite), 32'd0);
      checkOutput("reset address", bus.address, 32'd0);
      checkOutput("reset writeData", bus.writeData, 32'd0);
      reset_n = 1'b1;

      $display("[TB] directed vectors");
      for (int v = 0; v < 18; v++) begin
         refModel(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].ad, vecs[v].wd,
                  e_err, e_rd, e_lat, e_reads, e_writes, e_wword);
         applyStimulus(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].ad, vecs[v].wd);
         checkOutput($sformatf("vec%0d error", v), 32'(obs_error), 32'(vecs[v].err));
         checkOutput($sformatf("vec%0d rdata", v), obs_rdata, vecs[v].rdata);
         checkOutput($sformatf("vec%0d latency", v), 32'(obs_latency), 32'(vecs[v].lat));
         checkOutput($sformatf("vec%0d reads", v), 32'(obs_reads), 32'(vecs[v].reads));
         checkOutput($sformatf("vec%0d writes", v), 32'(obs_writes), 32'(vecs[v].writes));
         if (vecs[v].writes != 0) begin
            checkOutput($sformatf("vec%0d waddr", v), obs_waddr, vecs[v].ad & 32'hFFFFFFFC);
            checkOutput($sformatf("vec%0d wdata", v), obs_wdata, vecs[v].wword);
         end
      end

      $display("[TB] randomized requests");
      for (int k = 0; k < 80; k++) begin
         r_wr = 1'($urandom_range(0, 1));
         r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_sg = 1'($urandom_range(0, 1));
         r_ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 67));
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == 2'd1) r_ad[0] = 1'b0;
            if (r_sz == 2'd2) r_ad[1:0] = 2'b00;
         end
         r_wd = $urandom;
         refModel(r_wr, r_sz, r_sg, r_ad, r_wd, e_err, e_rd, e_lat, e_reads, e_writes, e_wword);
         applyStimulus(r_wr, r_sz, r_sg, r_ad, r_wd);
         checkOutput($sformatf("rand%0d error", k), 32'(obs_error), 32'(e_err));
         checkOutput($sformatf("rand%0d rdata", k), obs_rdata, e_rd);
         checkOutput($sformatf("rand%0d latency", k), 32'(obs_latency), 32'(e_lat));
         checkOutput($sformatf("rand%0d reads", k), 32'(obs_reads), 32'(e_reads));
         checkOutput($sformatf("rand%0d writes", k), 32'(obs_writes), 32'(e_writes));
         if (e_writes != 0) checkOutput($sformatf("rand%0d wdata", k), obs_wdata, e_wword);
      end

      $display("[TB] reset during CAPTURE of a byte store");
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'd9;
      bus.req_wdata  = 32'h00000077;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      checkOutput("midreset READ strobe", 32'(bus.memoryRead), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("midreset resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("midreset resp_error", 32'(bus.resp_error), 32'd0);
      checkOutput("midreset resp_rdata", bus.resp_rdata, 32'd0);
      checkOutput("midreset memoryRead", 32'(bus.memoryRead), 32'd0);
      checkOutput("midreset memoryWrite", 32'(bus.memoryWrite), 32'd0);
      checkOutput("midreset address", bus.address, 32'd0);
      checkOutput("midreset writeData", bus.writeData, 32'd0);
`ifdef LSU_PERF_CNT_EN
      checkOutput("midreset load_count", 32'(load_count), 32'd0);
      checkOutput("midreset store_count", 32'(store_count), 32'd0);
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      checkOutput("midreset memory word 8",
                  {mem[8], mem[9], mem[10], mem[11]},
                  {ref_mem[8], ref_mem[9], ref_mem[10], ref_mem[11]});
      refModel(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, e_err, e_rd, e_lat, e_reads, e_writes, e_wword);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
      checkOutput("midreset reload word 8", obs_rdata, e_rd);
      checkOutput("midreset reload latency", 32'(obs_latency), 32'd3);

`ifdef LSU_PERF_CNT_EN
      $display("[TB] performance counters");
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'd1, 32'd0);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'd5, 32'h000000AB);
      refModel(1'b1, 2'd0, 1'b0, 32'd5, 32'h000000AB, e_err, e_rd, e_lat, e_reads, e_writes, e_wword);
      applyStimulus(1'b0, 2'd3, 1'b0, 32'd4, 32'd0);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'd12, 32'h01020304);
      refModel(1'b1, 2'd2, 1'b0, 32'd12, 32'h01020304, e_err, e_rd, e_lat, e_reads, e_writes, e_wword);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'd2, 32'd0);
      @(negedge clk);
      checkOutput("perf load_count", 32'(load_count), 32'd3);
      checkOutput("perf store_count", 32'(store_count), 32'd2);
`endif

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the byte-addressed, big-endian 32-bit data memory; the processor's execute stage issues load/store requests into it.
- Converts byte, halfword and word accesses into the memory's word-only interface: aligns addresses, extracts and sign/zero-extends load data, and performs read-modify-write for sub-word stores.
- Serialised: one outstanding request at a time, with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- MEM_BYTES, 64: memory size in bytes; an aligned word address with addr[31:2]*4 + 3 >= MEM_BYTES is out of range.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and gives an error response
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  output  1  single-cycle completion pulse
- resp_error  output  1  valid with resp_valid: misaligned, illegal size or out of range
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors
- address  output  32  to memory: word-aligned address {addr[31:2],2'b00}
- writeData  output  32  to memory: full merged word
- memoryWrite  output  1  to memory: write strobe
- memoryRead  output  1  to memory: read strobe
- readData  input  32  from memory: registered read data, valid the cycle after memoryRead

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_error=0, resp_rdata=0.
  - memoryRead=0, memoryWrite=0, address=0, writeData=0.
  - Latched request registers are cleared.
- Memory-side outputs decode only from state and latched registers; there is no combinational path from req_* to memory.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE:
  - Accepts on a rising edge with req_valid=1. Latches write, size, signed, addr and wdata.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Error (misaligned, size=11 or out of range) -> RESP with error set; no memory strobe is ever issued.
  - Word store -> WRITE.
  - Load or sub-word store -> READ.
- READ: memoryRead=1 for exactly one cycle -> CAPTURE.
- CAPTURE: readData is valid this cycle.
  - Load: extract the lane, extend it, register it into resp_rdata, then -> RESP.
  - Sub-word store: merge the new lane into readData, register the result into a merge register, then -> WRITE.
- WRITE: memoryWrite=1 for exactly one cycle, with writeData = merged word (or req_wdata for a word store) -> RESP.
- RESP: resp_valid=1 for one cycle, no backpressure -> IDLE. req_ready=0 here.
- Lane mapping (big-endian):
  - Byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half offset 0 -> [31:16], offset 2 -> [15:0].
- Latency from the accept edge to resp_valid high: error 1 cycle, word store 2, load 3, sub-word store 4.
- Back-to-back: a new request can be accepted on the edge that leaves RESP? No. IDLE is re-entered first, so the minimum spacing between accepts is latency+1 cycles.
- Reset mid-operation: strobes drop immediately and no response is generated. A write has committed only if the WRITE-state rising edge occurred before reset asserted, so no partial merge is ever written.
- Unselected memory bytes are always rewritten with their just-read values, so a sub-word store never corrupts neighbouring bytes.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined:
  - Adds output ports load_count[15:0] and store_count[15:0].
  - Each increments on a non-error RESP of its type and saturates at 0xFFFF.
  - Error responses are counted in neither. Both reset to 0.
- Undefined: ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word store 0xA1B2C3D4 at addr 8 -> memoryWrite for 1 cycle with address=8, writeData=0xA1B2C3D4; resp_valid 2 cycles after accept, resp_error=0.
- Load byte addr 9 with signed=1 -> resp_rdata=0xFFFFFFB2; same with signed=0 -> 0x000000B2; half addr 10 signed -> 0xFFFFC3D4. Each responds 3 cycles after accept.
- Store byte 0x55 at addr 10 -> memoryRead then memoryWrite with writeData=0xA1B255D4; response 4 cycles after accept; a following word load at addr 8 returns 0xA1B255D4.
- Each error case -> resp_error=1 and resp_rdata=0 one cycle after accept, with memoryRead and memoryWrite never asserted:
  - word load at addr 6
  - half store at addr 3
  - size=11
  - word load at addr 64 (MEM_BYTES=64)
- Assert reset_n=0 during CAPTURE of a byte store -> no memoryWrite; the word at addr 8 is unchanged; all outputs return to reset values asynchronously.
- With LSU_PERF_CNT_EN: 3 good loads, 2 good stores and 1 error -> load_count=3, store_count=2.
